// File: rtl/muldiv_ctrl_pkg.sv
// Shared encodings for the RV32M iterative multiply/divide unit: op codes,
// controller states and the iteration count.
package muldiv_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_CALC = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_e;

    localparam int ITER_COUNT = 32;
    localparam int CNT_W      = $clog2(ITER_COUNT);

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Issue/completion bundle between the EX stage and the multiply/divide unit.
interface muldiv_ctrl_if #(parameter int XLEN = 32);

    logic            Start;
    logic [2:0]      MulDivOp;
    logic [XLEN-1:0] Operand1;
    logic [XLEN-1:0] Operand2;
    logic            Flush;
    logic            Busy;
    logic            Done;
    logic [XLEN-1:0] Result;

    modport master (
        output Start, MulDivOp, Operand1, Operand2, Flush,
        input  Busy, Done, Result
    );

    modport slave (
        input  Start, MulDivOp, Operand1, Operand2, Flush,
        output Busy, Done, Result
    );

endinterface

// File: rtl/muldiv_datapath.sv
// Radix-2 shift-add multiply / restoring divide datapath: {hi, lo} accumulator,
// operand magnitude register, 33-bit add/subtract and the sign fixup.
module muldiv_datapath #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic            step_i,
    input  logic            div_i,
    input  logic            fix_i,
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    input  logic            a_neg_i,
    input  logic            b_neg_i,
    input  logic            res_neg_i,
    input  logic            hi_sel_i,
    output logic [XLEN-1:0] word_o
);

    logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d, b_q, b_d;
    logic [XLEN-1:0]   abs1, abs2, div_word;
    logic [XLEN:0]     mul_sum, rem_sh, div_diff;
    logic              div_ok, negate;
    logic [2*XLEN-1:0] prod;

    assign abs1   = a_neg_i ? -op1_i : op1_i;
    assign abs2   = b_neg_i ? -op2_i : op2_i;
    assign negate = fix_i & res_neg_i;

    assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    assign rem_sh   = {hi_q, lo_q[XLEN-1]};
    assign div_diff = rem_sh - {1'b0, b_q};
    // A set top bit in the shifted remainder already exceeds any divisor.
    assign div_ok   = rem_sh[XLEN] | ~div_diff[XLEN];

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        b_d  = b_q;
        if (load_i) begin
            hi_d = '0;
            lo_d = div_i ? abs1 : abs2;
            b_d  = div_i ? abs2 : abs1;
        end else if (step_i) begin
            if (!div_i) begin
                hi_d = mul_sum[XLEN:1];
                lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
            end else if (div_ok) begin
                hi_d = div_diff[XLEN-1:0];
                lo_d = {lo_q[XLEN-2:0], 1'b1};
            end else begin
                hi_d = rem_sh[XLEN-1:0];
                lo_d = {lo_q[XLEN-2:0], 1'b0};
            end
        end
    end

    always_comb begin
        div_word = hi_sel_i ? hi_q : lo_q;
        prod     = negate ? -{hi_q, lo_q} : {hi_q, lo_q};
        if (div_i) begin
            word_o = negate ? -div_word : div_word;
        end else begin
            word_o = hi_sel_i ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
            b_q  <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
            b_q  <= b_d;
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// RV32M iterative multiply/divide controller: FSM, iteration counter, special
// cases and handshake. MULDIV_FASTPATH_EN lets trivial ops skip the iterations.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic          clk,
    input  logic          rst,
    muldiv_ctrl_if.slave  bus
);

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    state_e          state_q, state_d;
    muldiv_op_e      op_q;
    logic [XLEN-1:0] op1_q, op2_q, result_q, result_d, spec_val_q, spec_val_d, dp_word;
    logic [CNT_W-1:0] cnt_q;
    logic            spec_q, spec_d, accept, load_result;
    logic            is_div, a_neg, b_neg, res_neg, hi_sel;

    assign accept  = bus.Start & ~bus.Flush & ((state_q == S_IDLE) | (state_q == S_DONE));
    assign is_div  = op_q[2];
    assign a_neg   = op1_q[XLEN-1] & (op_q inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
    assign b_neg   = op2_q[XLEN-1] & (op_q inside {OP_MULH, OP_DIV, OP_REM});
    assign res_neg = (op_q == OP_REM) ? a_neg : (a_neg ^ b_neg);
    assign hi_sel  = op_q inside {OP_MULH, OP_MULHSU, OP_MULHU, OP_REM, OP_REMU};

    // Special-case results, evaluated from the latched operands during PREP.
    always_comb begin
        spec_d     = 1'b0;
        spec_val_d = '0;
        if (is_div && op2_q == '0) begin
            spec_d     = 1'b1;
            spec_val_d = op_q[1] ? op1_q : '1;
        end else if ((op_q == OP_DIV || op_q == OP_REM) && op1_q == INT_MIN && op2_q == '1) begin
            spec_d     = 1'b1;
            spec_val_d = op_q[1] ? '0 : INT_MIN;
        end
`ifdef MULDIV_FASTPATH_EN
        else if (!is_div && (op1_q == '0 || op2_q == '0)) begin
            spec_d     = 1'b1;
            spec_val_d = '0;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = S_PREP;
`ifdef MULDIV_FASTPATH_EN
            S_PREP: state_d = spec_d ? S_DONE : S_CALC;
`else
            S_PREP: state_d = S_CALC;
`endif
            S_CALC: if (cnt_q == '0) state_d = S_FIX;
            S_FIX:  state_d = S_DONE;
            S_DONE: state_d = accept ? S_PREP : S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (bus.Flush) state_d = S_IDLE;
    end

    always_comb begin
        load_result = 1'b0;
        result_d    = dp_word;
        if (state_q == S_FIX) begin
            load_result = 1'b1;
            result_d    = spec_q ? spec_val_q : dp_word;
        end
`ifdef MULDIV_FASTPATH_EN
        else if (state_q == S_PREP && spec_d) begin
            load_result = 1'b1;
            result_d    = spec_val_d;
        end
`endif
        if (bus.Flush) load_result = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            op_q       <= OP_MUL;
            op1_q      <= '0;
            op2_q      <= '0;
            cnt_q      <= '0;
            spec_q     <= 1'b0;
            spec_val_q <= '0;
            result_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q  <= muldiv_op_e'(bus.MulDivOp);
                op1_q <= bus.Operand1;
                op2_q <= bus.Operand2;
            end
            if (state_q == S_PREP) begin
                cnt_q      <= CNT_W'(ITER_COUNT - 1);
                spec_q     <= spec_d;
                spec_val_q <= spec_val_d;
            end else if (state_q == S_CALC && cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (load_result) result_q <= result_d;
        end
    end

    muldiv_datapath #(.XLEN(XLEN)) u_datapath (
        .clk       (clk),
        .rst       (rst),
        .load_i    (state_q == S_PREP),
        .step_i    (state_q == S_CALC),
        .div_i     (is_div),
        .fix_i     (state_q == S_FIX),
        .op1_i     (op1_q),
        .op2_i     (op2_q),
        .a_neg_i   (a_neg),
        .b_neg_i   (b_neg),
        .res_neg_i (res_neg),
        .hi_sel_i  (hi_sel),
        .word_o    (dp_word)
    );

    assign bus.Busy   = state_q inside {S_PREP, S_CALC, S_FIX};
    assign bus.Done   = (state_q == S_DONE);
    assign bus.Result = result_q;

endmodule
